// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, req/ack instruction-memory port,
// one-entry skid buffer and valid/ready output toward decode, with redirect squash.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        xfer;
    logic        consume;

    // DRAIN keeps presenting the squashed request until memory completes it.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            FETCH:   imem_req = !skid_valid;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: ;
        endcase
    end

    assign xfer    = (state == FETCH) && imem_req && imem_ack;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            drain_addr      <= '0;
            skid_valid      <= 1'b0;
            skid_instr      <= '0;
            skid_pc         <= '0;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            out_pc_plus4    <= '0;
        end else if (redirect_valid) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= redirect_pc & ~32'h3;
            case (state)
                FETCH: if (imem_req && !imem_ack) begin
                    state      <= DRAIN;
                    drain_addr <= pc;
                end
                DRAIN: if (imem_ack) state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                DRAIN:   if (imem_ack) state <= FETCH;
                default: ;
            endcase
            if (xfer) begin
                pc <= pc + 32'd4;
                if (!out_valid || out_ready) begin
                    out_valid       <= 1'b1;
                    out_instruction <= imem_rdata;
                    out_pc          <= pc;
                    out_pc_plus4    <= pc + 32'd4;
                end else begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= pc;
                end
            end else if (consume) begin
                // A transfer can never coincide with a full skid, so this is the only drain path.
                if (skid_valid) begin
                    skid_valid      <= 1'b0;
                    out_instruction <= skid_instr;
                    out_pc          <= skid_pc;
                    out_pc_plus4    <= skid_pc + 32'd4;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: model predicts the accepted instruction
// stream (sequential PCs restarting at each redirect target) from a scrambled memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_rdata = memf(imem_addr);

    int nvec = 0;
    int nerr = 0;
    int ncons = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected accepted PCs, refilled sequentially, flushed by redirect.
    logic [31:0] expq[$];
    logic [31:0] mpc = 32'h0000_3000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expq.delete();
            mpc = 32'h0000_3000;
        end else begin
            if (redirect_valid) begin
                expq.delete();
                mpc = redirect_pc & ~32'h3;
            end
            while (expq.size() < 8) begin
                expq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    end

    // Monitor: output scoreboard plus request/output stability checks.
    logic        req_pend = 1'b0;
    logic [31:0] req_addr = '0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_pc = '0;

    always @(negedge clk) begin
        if (rst) begin
            req_pend  = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (req_pend) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, req_addr);
            end
            if (imem_req && imem_ack) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
            req_pend = imem_req && !imem_ack;
            req_addr = imem_addr;
            if (hold_pend) begin
                chk("out_hold_valid", 32'(out_valid), 32'd1);
                chk("out_hold_pc", out_pc, hold_pc);
            end
            hold_pend = out_valid && !out_ready && !redirect_valid;
            hold_pc   = out_pc;
            if (out_valid && out_ready) begin
                ncons++;
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL out_unexpected: got pc %h expected no output", out_pc);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    chk("out_pc", out_pc, e);
                    chk("out_instr", out_instruction, memf(e));
                    chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", out_instruction, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_pc4", out_pc_plus4, 32'd0);

        // Zero-wait streaming: IDLE one cycle, then one fetch per cycle.
        rst = 1'b0; imem_ack = 1'b1; out_ready = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            chk("seq_addr", imem_addr, 32'h3000 + 32'(4 * i));
            if (i > 0) chk("throughput", 32'(out_valid), 32'd1);
            step();
        end

        // Stall the consumer: skid fills and requests stop.
        out_ready = 1'b0;
        step();
        chk("skid_req0", 32'(imem_req), 32'd0);
        step(); step(); step();
        chk("skid_req1", 32'(imem_req), 32'd0);
        out_ready = 1'b1;
        step();

        // Redirect with a request outstanding, drain completes two cycles later.
        imem_ack = 1'b0;
        step(); step();
        chk("pre_redir_req", 32'(imem_req), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4002;
        step();
        redirect_valid = 1'b0;
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        step();
        imem_ack = 1'b1;
        step();
        chk("post_drain_addr", imem_addr, 32'h0000_4000);
        step(); step(); step();

        // Redirect coinciding with an ack and a consume.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5008;
        step();
        redirect_valid = 1'b0;
        chk("redir_ack_valid", 32'(out_valid), 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h0000_5008);
        step(); step();

        // Reset asserted mid-DRAIN clears outputs without waiting for a clock.
        imem_ack = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_6000;
        step();
        redirect_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc", out_pc, 32'd0);
        chk("async_instr", out_instruction, 32'd0);
        step();
        rst = 1'b0; imem_ack = 1'b1;
        step();
        chk("restart_addr", imem_addr, 32'h0000_3000);

        // Randomized phases with varying memory latency and consumer readiness.
        for (int ph = 0; ph < 3; ph++) begin
            int c0;
            int ack_p;
            int rdy_p;
            c0 = ncons;
            ack_p = (ph == 0) ? 100 : (ph == 1) ? 50 : 25;
            rdy_p = (ph == 0) ? 80 : (ph == 1) ? 50 : 90;
            for (int c = 0; c < 1500; c++) begin
                imem_ack  = ($urandom_range(99) < ack_p);
                out_ready = ($urandom_range(99) < rdy_p);
                redirect_valid = ($urandom_range(99) < 3);
                redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(3)))
                                                       : $urandom;
                step();
            end
            redirect_valid = 1'b0;
            chk("progress", 32'(ncons - c0 > 100), 32'd1);
        end

        imem_ack = 1'b1; out_ready = 1'b1;
        repeat (10) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
